// File: rtl/booth_datapath.sv
// -----------------------------------------------------------------------------
// booth_datapath
//
// Datapath for a radix-2 Booth multiplier. An external controller sequences
// it through these registers:
//   M   : multiplicand (WIDTH bits)
//   Q   : multiplier / low half of the product (WIDTH bits)
//   A   : accumulator (WIDTH+1 bits, one guard sign bit)
//   qm1 : the q(-1) flip-flop
//   cnt : iteration counter (clog2(WIDTH)+1 bits)
//
// Optional feature: define BOOTH_DP_ERR_EN to add the sticky 'err' output.
// It flags a decr at count 0, or an ldA/sftA/sftQ while the count is 0 and
// ldcnt is low. Only rst or ldcnt clears it.
//
// Ports
//   clk                input   rising-edge clock
//   rst                input   synchronous active-high reset
//   data_in[WIDTH]     input   shared operand bus (M on ldM, Q on ldQ)
//   ldA/clrA/sftA      input   accumulator load add/sub result, clear, shift
//   ldQ/clrQ/sftQ      input   multiplier load, clear, shift
//   ldM                input   multiplicand load
//   clrff              input   clear q(-1)
//   addsub             input   1 = A+M, 0 = A-M (used on ldA)
//   ldcnt/decr         input   counter load WIDTH, decrement (saturates at 0)
//   q0                 output  Q[0]
//   qm1                output  q(-1)
//   eqz                output  counter == 0
//   err                output  sticky sequencing error (BOOTH_DP_ERR_EN only)
//   product[2*WIDTH]   output  {A[WIDTH-1:0], Q}
// -----------------------------------------------------------------------------
module booth_datapath #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 ldA,
    input  logic                 clrA,
    input  logic                 sftA,
    input  logic                 ldQ,
    input  logic                 clrQ,
    input  logic                 sftQ,
    input  logic                 ldM,
    input  logic                 clrff,
    input  logic                 addsub,
    input  logic                 ldcnt,
    input  logic                 decr,
    output logic                 q0,
    output logic                 qm1,
    output logic                 eqz,
`ifdef BOOTH_DP_ERR_EN
    output logic                 err,
`endif
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH:0]   a_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic             qm1_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   m_ext_s;
    logic [WIDTH:0]   addsub_s;
    logic             cnt_zero_s;

    // Add/subtract of the sign-extended multiplicand; the guard bit keeps
    // -2^(WIDTH-1) operands representable, carry-out is dropped.
    always_comb begin
        m_ext_s  = {m_r[WIDTH-1], m_r};
        addsub_s = {(WIDTH+1){1'b0}};
        if (addsub) begin
            addsub_s = a_r + m_ext_s;
        end else begin
            addsub_s = a_r - m_ext_s;
        end
    end

    assign cnt_zero_s = (cnt_r == CNT_ZERO);

    // Accumulator: clear > load > arithmetic shift right.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= {(WIDTH+1){1'b0}};
        end else if (clrA) begin
            a_r <= {(WIDTH+1){1'b0}};
        end else if (ldA) begin
            a_r <= addsub_s;
        end else if (sftA) begin
            a_r <= {a_r[WIDTH], a_r[WIDTH:1]};
        end else begin
            a_r <= a_r;
        end
    end

    // Multiplier: clear > load > shift; A[0] (pre-edge) enters the MSB
    // whether or not A itself shifts this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (clrQ) begin
            q_r <= {WIDTH{1'b0}};
        end else if (ldQ) begin
            q_r <= data_in;
        end else if (sftQ) begin
            q_r <= {a_r[0], q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    // Multiplicand register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r <= {WIDTH{1'b0}};
        end else if (ldM) begin
            m_r <= data_in;
        end else begin
            m_r <= m_r;
        end
    end

    // q(-1) flip-flop: clear > capture of Q[0] on a Q shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            qm1_r <= 1'b0;
        end else if (clrff) begin
            qm1_r <= 1'b0;
        end else if (sftQ) begin
            qm1_r <= q_r[0];
        end else begin
            qm1_r <= qm1_r;
        end
    end

    // Iteration counter: load > decrement, saturating at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (ldcnt) begin
            cnt_r <= CNT_LOAD;
        end else if (decr && !cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

`ifdef BOOTH_DP_ERR_EN
    logic err_r;

    // Sticky sequencing error; a fresh ldcnt starts a new operation cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (ldcnt) begin
            err_r <= 1'b0;
        end else if (cnt_zero_s && (decr || ldA || sftA || sftQ)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

    assign q0      = q_r[0];
    assign qm1     = qm1_r;
    assign eqz     = cnt_zero_s;
    assign product = {a_r[WIDTH-1:0], q_r};

endmodule

// File: tb/tb_booth_datapath.sv
module tb_booth_datapath;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcnt, decr;
    logic          q0, qm1, eqz;
    logic          err;
    logic [2*W-1:0] product;

`ifdef BOOTH_DP_ERR_EN
    booth_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .ldA(ldA), .clrA(clrA), .sftA(sftA),
        .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
        .ldM(ldM), .clrff(clrff), .addsub(addsub),
        .ldcnt(ldcnt), .decr(decr),
        .q0(q0), .qm1(qm1), .eqz(eqz), .err(err), .product(product)
    );
`else
    booth_datapath #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .ldA(ldA), .clrA(clrA), .sftA(sftA),
        .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
        .ldM(ldM), .clrff(clrff), .addsub(addsub),
        .ldcnt(ldcnt), .decr(decr),
        .q0(q0), .qm1(qm1), .eqz(eqz), .product(product)
    );
    assign err = 1'b0;
`endif

    typedef struct {
        string        name;
        logic [31:0]  product;
        logic         q0;
        logic         qm1;
        logic         eqz;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, required %h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the state presented by the DUT against queued expectations.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk1(e.name, "product", product, e.product);
            chk1(e.name, "q0", {31'd0, q0}, {31'd0, e.q0});
            chk1(e.name, "qm1", {31'd0, qm1}, {31'd0, e.qm1});
            chk1(e.name, "eqz", {31'd0, eqz}, {31'd0, e.eqz});
`ifdef BOOTH_DP_ERR_EN
            chk1(e.name, "err", {31'd0, err}, {31'd0, e.err});
`endif
        end
    end

    task automatic expect_state(input string nm, input logic [31:0] p, input logic em1,
                                input logic ez, input logic ee);
        exp_t e;
        e.name = nm; e.product = p; e.q0 = p[0]; e.qm1 = em1; e.eqz = ez; e.err = ee;
        sb.push_back(e);
    endtask

    task automatic clear_ctrl();
        ldA = 1'b0; clrA = 1'b0; sftA = 1'b0; ldQ = 1'b0; clrQ = 1'b0; sftQ = 1'b0;
        ldM = 1'b0; clrff = 1'b0; addsub = 1'b0; ldcnt = 1'b0; decr = 1'b0;
    endtask

    // One clock with the currently driven controls, then controls drop.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    // Full Booth sequence; decisions come from the multiplier value itself.
    task automatic run_booth(input string nm, input logic [15:0] m, input logic [15:0] q,
                             input logic [31:0] exp_p);
        logic prev;
        data_in = m; ldM = 1'b1; tick();
        data_in = q; ldQ = 1'b1; clrA = 1'b1; clrff = 1'b1; ldcnt = 1'b1; tick();
        expect_state({nm, "_start"}, {16'h0000, q}, 1'b0, 1'b0, 1'b0);
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ({q[i], prev} == 2'b01) begin
                ldA = 1'b1; addsub = 1'b1; tick();
            end else if ({q[i], prev} == 2'b10) begin
                ldA = 1'b1; addsub = 1'b0; tick();
            end
            sftA = 1'b1; sftQ = 1'b1; decr = 1'b1; tick();
            prev = q[i];
        end
        expect_state(nm, exp_p, q[15], 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        data_in = 16'h0000;
        clear_ctrl();
        data_in = 16'hFFFF; ldA = 1'b1; ldQ = 1'b1; ldM = 1'b1; ldcnt = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        expect_state("reset", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tick();

        run_booth("m3_qm5", 16'h0003, 16'hFFFB, 32'hFFFF_FFF1);
        run_booth("m7_q6", 16'h0007, 16'h0006, 32'h0000_002A);
        run_booth("mm8_qm8", 16'hFFF8, 16'hFFF8, 32'h0000_0040);
        run_booth("mmin_qmin", 16'h8000, 16'h8000, 32'h4000_0000);

        // Guard-bit shift: A = 0 - 0x7FFF = 17'h18001, Q = 3, qm1 = 0
        data_in = 16'h7FFF; ldM = 1'b1; clrA = 1'b1; clrff = 1'b1; ldcnt = 1'b1; tick();
        data_in = 16'h0003; ldA = 1'b1; addsub = 1'b0; ldQ = 1'b1; tick();
        expect_state("guard_setup", 32'h8001_0003, 1'b0, 1'b0, 1'b0);
        sftA = 1'b1; sftQ = 1'b1; tick();
        expect_state("guard_shift", 32'hC000_8001, 1'b1, 1'b0, 1'b0);
        sftA = 1'b1; tick();
        expect_state("sftA_only", 32'hE000_8001, 1'b1, 1'b0, 1'b0);
        clrA = 1'b1; ldA = 1'b1; addsub = 1'b1; tick();
        expect_state("clrA_over_ldA", 32'h0000_8001, 1'b1, 1'b0, 1'b0);
        sftQ = 1'b1; tick();
        expect_state("sftQ_only", 32'h0000_4000, 1'b1, 1'b0, 1'b0);
        clrff = 1'b1; sftQ = 1'b1; tick();
        expect_state("clrff_over_sftQ", 32'h0000_2000, 1'b0, 1'b0, 1'b0);

        // ldM and ldQ together share data_in
        data_in = 16'h1234; ldM = 1'b1; ldQ = 1'b1; tick();
        expect_state("ldM_ldQ", 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        ldA = 1'b1; addsub = 1'b1; tick();
        expect_state("add_M", 32'h1234_1234, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        expect_state("hold", 32'h1234_1234, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation at count 9
        ldcnt = 1'b1; tick();
        for (int i = 0; i < 7; i++) begin
            decr = 1'b1; tick();
        end
        sftQ = 1'b1; tick();
        expect_state("cnt9", 32'h1234_091A, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; data_in = 16'h5555; ldcnt = 1'b1; ldQ = 1'b1; tick();
        rst = 1'b0;
        expect_state("mid_reset", 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        // Counter saturation at zero (and sticky err when present)
        decr = 1'b1; tick();
        expect_state("decr_at_0", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        tick();
        expect_state("err_sticky", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        ldcnt = 1'b1; decr = 1'b1; tick();
        expect_state("ldcnt_over_decr", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            decr = 1'b1; tick();
        end
        expect_state("cnt1", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        decr = 1'b1; tick();
        expect_state("cnt0", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        sftA = 1'b1; tick();
        expect_state("sftA_at_0", 32'h0000_0000, 1'b0, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
